btn_led_ctrl: RTL and testbench

Front-end controller for the board's pushbutton-to-LED path. It synchronises and debounces the raw button and turns each press into a one-cycle event. A mode state machine advances on each press and sequences what drives the LED: inverted button, solid on, blink, or off. The block replaces a direct combinational button-to-LED hookup at top level.

---
 rtl/btn_led_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_btn_led_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_led_ctrl.sv
// btn_led_ctrl
//   Pushbutton-to-LED front end. The raw button is synchronised, debounced
//   and turned into a one-cycle press strobe. A mode machine steps on each
//   press and selects what drives the LED.
//
//   Ports
//     clk100mhz    in   system clock
//     rst_n        in   asynchronous active-low reset
//     btn          in   raw pushbutton, asynchronous, active-high
//     led          out  registered LED drive
//     mode[1:0]    out  current mode (00 INVERT, 01 SOLID, 10 BLINK, 11 OFF)
//     press_pulse  out  one-cycle strobe per accepted press
//
//   Build option
//     BTN_LONG_PRESS_EN  when defined, holding the button for
//                        LONG_PRESS_CYCLES forces the mode back to INVERT
//                        once per hold.
//
//   Mode states
//     state    | meaning
//     ---------+-----------------------------------------
//     M_INVERT | led follows the inverted debounced button
//     M_SOLID  | led held on
//     M_BLINK  | led toggles every BLINK_HALF_PERIOD cycles
//     M_OFF    | led held off
module btn_led_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int BLINK_HALF_PERIOD = 25000000,
    parameter int LONG_PRESS_CYCLES = 200000000
) (
    input  logic       clk100mhz,
    input  logic       rst_n,
    input  logic       btn,
    output logic       led,
    output logic [1:0] mode,
    output logic       press_pulse
);

    if (DEBOUNCE_CYCLES < 2 || BLINK_HALF_PERIOD < 2 || LONG_PRESS_CYCLES < 2) begin : g_param_err
        $error("btn_led_ctrl: cycle-count parameters must be at least 2");
    end

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int BW = $clog2(BLINK_HALF_PERIOD);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF_PERIOD - 1);

    typedef enum logic [1:0] {
        M_INVERT = 2'b00,
        M_SOLID  = 2'b01,
        M_BLINK  = 2'b10,
        M_OFF    = 2'b11
    } mode_t;

    logic [1:0]    sync_q;
    logic          btn_s;
    logic          btn_db;
    logic          btn_db_d;
    logic [DW-1:0] db_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_q;
    logic          long_fire;
    mode_t         mode_q;
    mode_t         mode_d;

    assign btn_s = sync_q[1];

    // Synchroniser, debouncer and press edge detect. The debounced level
    // only moves once btn_s has disagreed with it for DEBOUNCE_CYCLES
    // consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b00;
            btn_db      <= 1'b0;
            btn_db_d    <= 1'b0;
            db_cnt      <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], btn};
            btn_db_d    <= btn_db;
            press_pulse <= btn_db & ~btn_db_d;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    logic [HW-1:0] hold_cnt;
    logic          hold_done;

    // Hold counter saturates at its terminal value; hold_done keeps the
    // forced return to a single event per hold.
    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            hold_done <= 1'b0;
        end else if (!btn_db) begin
            hold_cnt  <= '0;
            hold_done <= 1'b0;
        end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HW'(1);
        end else begin
            hold_done <= 1'b1;
        end
    end

    assign long_fire = btn_db & (hold_cnt == HOLD_LAST) & ~hold_done;
`else
    assign long_fire = 1'b0;
`endif

    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= M_INVERT;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (press_pulse) begin
            case (mode_q)
                M_INVERT: mode_d = M_SOLID;
                M_SOLID:  mode_d = M_BLINK;
                M_BLINK:  mode_d = M_OFF;
                M_OFF:    mode_d = M_INVERT;
                default:  mode_d = M_INVERT;
            endcase
        end
        // The long-press return wins over a coincident normal step.
        if (long_fire) begin
            mode_d = M_INVERT;
        end
    end

    // Blink phase restarts on entry so the first half-period is always on.
    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (mode_d == M_BLINK && mode_q != M_BLINK) begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end else if (mode_q == M_BLINK) begin
            if (blink_cnt == BL_LAST) begin
                blink_cnt <= '0;
                blink_q   <= ~blink_q;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end else begin
            blink_cnt <= '0;
            blink_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            led <= 1'b1;
        end else begin
            case (mode_q)
                M_INVERT: led <= ~btn_db;
                M_SOLID:  led <= 1'b1;
                M_BLINK:  led <= blink_q;
                M_OFF:    led <= 1'b0;
                default:  led <= 1'b1;
            endcase
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_btn_led_ctrl.sv
module tb_btn_led_ctrl;

    localparam int D = 4;
    localparam int H = 3;
    localparam int L = 20;

    logic       clk100mhz = 1'b0;
    logic       rst_n     = 1'b1;
    logic       btn       = 1'b0;
    logic       led;
    logic [1:0] mode;
    logic       press_pulse;

    btn_led_ctrl #(
        .DEBOUNCE_CYCLES  (D),
        .BLINK_HALF_PERIOD(H),
        .LONG_PRESS_CYCLES(L)
    ) dut (
        .clk100mhz  (clk100mhz),
        .rst_n      (rst_n),
        .btn        (btn),
        .led        (led),
        .mode       (mode),
        .press_pulse(press_pulse)
    );

    always #5 clk100mhz = ~clk100mhz;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pulses = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Debounced level flips once the raw samples that reached the
    // synchroniser output over the last D edges all disagree with it.
    bit         hist[$];
    logic       m_db, m_rose, m_pulse, m_led;
    logic [1:0] m_mode;
    int         blink_age, hold_age;
    logic [1:0] exp_q[$];

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < D + 2; i++) hist.push_back(1'b0);
        m_db = 0; m_rose = 0; m_pulse = 0; m_led = 1; m_mode = 2'd0;
        blink_age = 0; hold_age = 0;
        exp_q = {};
    endtask

    task automatic model_step(input logic b);
        logic       db_prev;
        logic [1:0] mode_prev, mode_new, nxt;
        bit         flip;
        db_prev   = m_db;
        mode_prev = m_mode;
        hist.push_back(b);
        if (hist.size() > D + 2) void'(hist.pop_front());
        flip = 1'b1;
        for (int i = 0; i < D; i++) if (hist[i] == db_prev) flip = 1'b0;
        case (mode_prev)
            2'd0: m_led = ~db_prev;
            2'd1: m_led = 1'b1;
            2'd2: m_led = ((blink_age / H) % 2 == 0);
            default: m_led = 1'b0;
        endcase
        mode_new = m_pulse ? mode_prev + 2'd1 : mode_prev;
`ifdef BTN_LONG_PRESS_EN
        hold_age = db_prev ? hold_age + 1 : 0;
        if (hold_age == L) mode_new = 2'd0;
`endif
        if (mode_new == 2'd2 && mode_prev != 2'd2) blink_age = 0;
        else if (mode_prev == 2'd2) blink_age++;
        m_pulse = m_rose;
        m_rose  = flip & ~db_prev;
        m_db    = flip ? ~db_prev : db_prev;
        m_mode  = mode_new;
        if (m_pulse) begin
            nxt = mode_new + 2'd1;
            exp_q.push_back(nxt);
        end
    endtask

    always @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step(btn);
    end

    // ---------------- monitor / scoreboard ----------------
    logic       pend = 1'b0;
    logic [1:0] pend_mode;

    always @(negedge clk100mhz) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("press_mode_step", int'(mode), int'(pend_mode));
                pend = 1'b0;
            end
            chk("led", int'(led), int'(m_led));
            chk("mode", int'(mode), int'(m_mode));
            chk("press_pulse", int'(press_pulse), int'(m_pulse));
            if (press_pulse) begin
                n_pulses++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_press", 1, 0);
                end else begin
                    pend_mode = exp_q.pop_front();
                    pend = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk100mhz);
        #2 rst_n = 1'b0;
        @(negedge clk100mhz);
        @(negedge clk100mhz);
        #2 rst_n = 1'b1;
    endtask

    task automatic press(input int hold, input int gap);
        repeat (hold) begin @(negedge clk100mhz); btn = 1'b1; end
        repeat (gap)  begin @(negedge clk100mhz); btn = 1'b0; end
    endtask

    task automatic wait_mode(input logic [1:0] target, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk100mhz);
            if (mode == target) found = 1'b1;
        end
        chk("wait_mode_reached", int'(found), 1);
    endtask

    int exp_seq[4]   = '{1, 2, 3, 0};
    int blink_exp[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    int p0;

    initial begin
        // 1: reset values and INVERT latency
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk100mhz);
        chk("rst_mode", int'(mode), 0);
        chk("rst_led", int'(led), 1);
        chk("rst_pulse", int'(press_pulse), 0);
        #2 rst_n = 1'b1;
        @(negedge clk100mhz);
        btn = 1'b1;
        repeat (6) @(negedge clk100mhz);
        chk("latency_led_before", int'(led), 1);
        @(negedge clk100mhz);
        chk("latency_led_at7", int'(led), 0);
        press(0, 14);

        // 2: bounce rejected, then one clean press
        do_reset();
        p0 = n_pulses;
        repeat (5) press(3, 1);
        press(0, 10);
        chk("bounce_mode", int'(mode), 0);
        chk("bounce_pulses", n_pulses - p0, 0);
        press(10, 12);
        chk("clean_mode", int'(mode), 1);
        chk("clean_led", int'(led), 1);
        chk("clean_pulses", n_pulses - p0, 1);

        // 3: cycling through all modes
        do_reset();
        p0 = n_pulses;
        for (int i = 0; i < 4; i++) begin
            press(10, 12);
            chk("cycle_mode", int'(mode), exp_seq[i]);
            if (exp_seq[i] == 3) chk("off_led", int'(led), 0);
        end
        chk("cycle_pulses", n_pulses - p0, 4);

        // 4: blink waveform from BLINK entry
        do_reset();
        press(10, 12);
        @(negedge clk100mhz);
        btn = 1'b1;
        wait_mode(2'd2, 20);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk100mhz);
            chk("blink_led", int'(led), blink_exp[i]);
        end
        press(0, 12);

        // 5: reset mid-blink with the debouncer counting
        @(negedge clk100mhz);
        btn = 1'b1;
        repeat (4) @(posedge clk100mhz);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mode", int'(mode), 0);
        chk("midrst_led", int'(led), 1);
        chk("midrst_pulse", int'(press_pulse), 0);
        @(negedge clk100mhz);
        btn = 1'b0;
        @(negedge clk100mhz);
        #2 rst_n = 1'b1;
        p0 = n_pulses;
        repeat (20) @(negedge clk100mhz);
        chk("midrst_no_pulse", n_pulses - p0, 0);

`ifdef BTN_LONG_PRESS_EN
        // 6: long press from SOLID
        do_reset();
        press(10, 12);
        @(negedge clk100mhz);
        btn = 1'b1;
        wait_mode(2'd2, 12);
        wait_mode(2'd0, 25);
        repeat (8) @(negedge clk100mhz);
        chk("long_hold_mode", int'(mode), 0);
        press(0, 12);
        chk("long_release_mode", int'(mode), 0);
`endif

        // 7: button held across reset release
        @(negedge clk100mhz);
        btn = 1'b1;
        do_reset();
        p0 = n_pulses;
        wait_mode(2'd1, 15);
        press(0, 12);
        chk("held_rst_pulses", n_pulses - p0, 1);

        // random runs, short glitches mixed with accepted presses
        do_reset();
        for (int i = 0; i < 120; i++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            repeat (len) begin @(negedge clk100mhz); btn = v; end
        end
        press(0, 14);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
